tlv5618_sched: RTL

TLV5618_SCHED -- requirements
Module: tlv5618_sched

---
 rtl/tlv5618_sched.sv | 135 +++++++++++++
 1 files changed

// File: rtl/tlv5618_sched.sv
// Request scheduler for the TLV5618 dual 12-bit DAC serial driver.
// Arbitrates channel A/B update requests, builds the 16-bit control word
// {R1,SPD,PWR,R0,code}, issues it with a start pulse and waits for set_done.
module tlv5618_sched #(
  parameter logic        SPD     = 1'b1,
  parameter logic        PWR     = 1'b0,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [11:0] a_data,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [11:0] b_data,
  output logic        b_ack,
  input  logic        pair_en,
  output logic        start,
  output logic [15:0] dac_data,
  input  logic        set_done,
  output logic        busy,
  output logic        timeout
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          own_a, own_b;     // channels acked when the transaction ends
  logic          pair_first;       // first (buffer-only) word of a pair in flight
  logic          to_flag;          // transaction abandoned on timeout
  logic          last_grant_b;     // 1: last single grant went to B
  logic [11:0]   code_a;           // captured A code for the pair second word

  logic grant_a, grant_b, grant_pair, second, expire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, arbitration decisions and pulse outputs
  always_comb begin
    state_nxt  = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    grant_pair = 1'b0;
    second     = 1'b0;
    expire     = 1'b0;
    start      = 1'b0;
    a_ack      = 1'b0;
    b_ack      = 1'b0;
    timeout    = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (a_req && b_req) begin
          if (pair_en)           grant_pair = 1'b1;
          else if (last_grant_b) grant_a    = 1'b1;
          else                   grant_b    = 1'b1;
          state_nxt = ISSUE;
        end else if (a_req) begin
          grant_a   = 1'b1;
          state_nxt = ISSUE;
        end else if (b_req) begin
          grant_b   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        start     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (set_done) begin
          if (pair_first) begin
            second    = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = DONE;
          end
        end else if (cnt == CNT_LAST) begin
          expire    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        a_ack     = own_a;
        b_ack     = own_b;
        timeout   = to_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction context, output word and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      own_a        <= 1'b0;
      own_b        <= 1'b0;
      pair_first   <= 1'b0;
      to_flag      <= 1'b0;
      last_grant_b <= 1'b1;
      code_a       <= '0;
      dac_data     <= '0;
      cnt          <= '0;
    end else begin
      if (grant_a || grant_b || grant_pair) begin
        own_a      <= grant_a | grant_pair;
        own_b      <= grant_b | grant_pair;
        pair_first <= grant_pair;
        to_flag    <= 1'b0;
        code_a     <= a_data;
        if (grant_b)         dac_data <= {1'b0, SPD, PWR, 1'b0, b_data};
        else if (grant_pair) dac_data <= {1'b0, SPD, PWR, 1'b1, b_data};
        else                 dac_data <= {1'b1, SPD, PWR, 1'b0, a_data};
        if (!grant_pair) last_grant_b <= grant_b;
      end
      if (second) begin
        pair_first <= 1'b0;
        dac_data   <= {1'b1, SPD, PWR, 1'b0, code_a};
      end
      if (expire) to_flag <= 1'b1;
      if (state == WAIT && state_nxt == WAIT) cnt <= cnt + CW'(1);
      else                                    cnt <= '0;
    end
  end

endmodule
